// File: rtl/uart_pkg.sv
// UART shared definitions: bit timing default, FSM encoding,
// and the byte bundle handed from the frame decoder to the output stage.
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 868;
    localparam int UART_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } uart_state_t;

    typedef struct packed {
        logic       valid;
        logic [7:0] data;
    } uart_byte_t;

    function automatic int uart_cnt_width(input int clks);
        return (clks > 1) ? $clog2(clks) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Reset value is configurable so idle-high lines come up idle.
module sync_2ff #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // two-stage capture into the clk domain
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1, mid-bit sampling, single-entry output register
// with valid/ready handshake; never stalls the line on the consumer.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int            CW       = uart_cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_MAX = CW'(CLKS_PER_BIT / 2 - 1);

    logic        rx_s;
    uart_state_t state;
    uart_state_t state_n;
    logic [CW-1:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    uart_byte_t  pend;

    logic half_done;
    logic full_done;
    logic cnt_clr;
    logic cnt_inc;
    logic shift_en;
    logic stop_good;
    logic stop_bad;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (rx),
        .q  (rx_s)
    );

    assign half_done = (cnt == HALF_MAX);
    assign full_done = (cnt == FULL_MAX);

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // next-state decode from line level and bit timing
    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE: begin
                if (!rx_s) state_n = ST_START;
            end
            ST_START: begin
                if (half_done) state_n = rx_s ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (full_done && bit_idx == 3'd7) state_n = ST_STOP;
            end
            ST_STOP: begin
                if (full_done) state_n = rx_s ? ST_IDLE : ST_WAIT_IDLE;
            end
            ST_WAIT_IDLE: begin
                if (rx_s) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // per-state strobes for the counter, shifter and stop check
    always_comb begin
        busy      = (state != ST_IDLE);
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        shift_en  = 1'b0;
        stop_good = 1'b0;
        stop_bad  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                cnt_clr = 1'b1;
            end
            ST_START: begin
                if (half_done) cnt_clr = 1'b1;
                else           cnt_inc = 1'b1;
            end
            ST_DATA: begin
                if (full_done) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_STOP: begin
                if (full_done) begin
                    cnt_clr   = 1'b1;
                    stop_good = rx_s;
                    stop_bad  = !rx_s;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                cnt_clr = 1'b1;
            end
            default: begin
                cnt_clr = 1'b1;
            end
        endcase
    end

    // bit-timing counter
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (cnt_inc) begin
            cnt <= cnt + CW'(1);
        end
    end

    // bit index and LSB-first shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
        end else if (state != ST_DATA) begin
            bit_idx <= 3'd0;
        end else if (shift_en) begin
            shreg[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 3'd1;
        end
    end

    // stop-bit outcome: stage a good byte, pulse on a bad stop
    always_ff @(posedge clk) begin
        if (rst) begin
            pend      <= '0;
            frame_err <= 1'b0;
        end else begin
            pend.valid <= stop_good;
            pend.data  <= shreg;
            frame_err  <= stop_bad;
        end
    end

    // output register: load, hold, or drop with overrun pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_valid <= 1'b0;
            rx_data  <= 8'h00;
            overrun  <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (pend.valid) begin
                if (!rx_valid || rx_ready) begin
                    rx_valid <= 1'b1;
                    rx_data  <= pend.data;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level timing model at
// CLKS_PER_BIT=16 plus a skewed-baud run at CLKS_PER_BIT=868.
module tb_uart_rx;

    localparam int C  = 16;
    localparam int H  = C / 2;
    localparam int CS = 868;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    logic       rx2 = 1'b1;
    logic       rx_ready2 = 1'b1;
    logic [7:0] rx_data2;
    logic       rx_valid2;
    logic       frame_err2;
    logic       overrun2;
    logic       busy2;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(C)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_ready (rx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    uart_rx #(.CLKS_PER_BIT(CS)) u_dut_slow (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx2),
        .rx_ready (rx_ready2),
        .rx_data  (rx_data2),
        .rx_valid (rx_valid2),
        .frame_err(frame_err2),
        .overrun  (overrun2),
        .busy     (busy2)
    );

    typedef struct {
        int         n;
        logic [7:0] b;
    } dev_t;

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         k_last = 0;

    dev_t       dq[$];
    int         fq[$];
    int         bs[$];
    int         be[$];

    logic       m_valid = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       old_v;
    logic       e_ovr;
    logic       e_ferr;
    logic       e_busy;

    logic       prev_valid = 1'b0;
    int         rise_n = -1;
    int         rises = 0;
    logic [7:0] rise_data[$];
    int         ferr_cnt = 0;
    int         ovr_cnt = 0;

    logic [7:0] got2[$];
    int         err2 = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s @cyc %0d: got %0h want %0h",
                         name, cyc, act, exp);
        end
    endtask

    // model + per-cycle compare, sampled 1 time unit after each edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            e_ovr  = 1'b0;
            e_ferr = 1'b0;
            e_busy = 1'b0;
            if (rst) begin
                m_valid = 1'b0;
                m_data  = 8'h00;
            end else begin
                old_v = m_valid;
                if (old_v && rx_ready) m_valid = 1'b0;
                if (dq.size() > 0 && dq[0].n == cyc) begin
                    if (!old_v || rx_ready) begin
                        m_valid = 1'b1;
                        m_data  = dq[0].b;
                    end else begin
                        e_ovr = 1'b1;
                    end
                    void'(dq.pop_front());
                end
                if (fq.size() > 0 && fq[0] == cyc) begin
                    e_ferr = 1'b1;
                    void'(fq.pop_front());
                end
            end
            for (int i = 0; i < bs.size(); i++)
                if (cyc >= bs[i] && cyc < be[i]) e_busy = 1'b1;

            check("rx_valid", 32'(rx_valid), 32'(m_valid));
            check("rx_data", 32'(rx_data), 32'(m_data));
            check("frame_err", 32'(frame_err), 32'(e_ferr));
            check("overrun", 32'(overrun), 32'(e_ovr));
            check("busy", 32'(busy), 32'(e_busy));

            if (rx_valid && !prev_valid) begin
                rises++;
                rise_n = cyc;
                rise_data.push_back(rx_data);
            end
            prev_valid = rx_valid;
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;

            if (rx_valid2) got2.push_back(rx_data2);
            if (frame_err2 || overrun2) err2++;
        end
    end

    // one 8N1 frame at C clocks per bit; optional rst mid data bit
    task automatic send(input logic [7:0] b, input bit stop_ok,
                        input int rst_bit);
        int k;
        @(negedge clk);
        rx = 1'b0;
        k = cyc + 1;
        k_last = k;
        bs.push_back(k + 2);
        if (rst_bit >= 0) begin
            be.push_back(k + (rst_bit + 1) * C + H);
        end else if (stop_ok) begin
            dq.push_back('{k + 3 + H + 9 * C, b});
            be.push_back(k + 2 + H + 9 * C);
        end else begin
            fq.push_back(k + 2 + H + 9 * C);
            be.push_back(32'h7fff_ffff);
        end
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (i == rst_bit) begin
                repeat (H) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                repeat (C - H - 1) @(negedge clk);
            end else begin
                repeat (C) @(negedge clk);
            end
        end
        rx = stop_ok;
        repeat (C) @(negedge clk);
    endtask

    // short low pulse on an idle line
    task automatic glitch(input int g);
        int k;
        @(negedge clk);
        rx = 1'b0;
        k = cyc + 1;
        bs.push_back(k + 2);
        be.push_back(k + 2 + H);
        repeat (g) @(negedge clk);
        rx = 1'b1;
    endtask

    // frame for the 868 instance at an arbitrary bit period
    task automatic send2(input logic [7:0] b, input int p);
        @(negedge clk);
        rx2 = 1'b0;
        repeat (p) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx2 = b[i];
            repeat (p) @(negedge clk);
        end
        rx2 = 1'b1;
        repeat (p) @(negedge clk);
    endtask

    logic [7:0] exp_r[4];
    logic [7:0] exp_s[3];
    int         k_a5;

    initial begin
        exp_r[0] = 8'hA5;
        exp_r[1] = 8'h5A;
        exp_r[2] = 8'h11;
        exp_r[3] = 8'h81;
        exp_s[0] = 8'h00;
        exp_s[1] = 8'hFF;
        exp_s[2] = 8'h55;

        repeat (3) @(negedge clk);
        check("reset rx_data", 32'(rx_data), 32'h00);
        check("reset rx_valid", 32'(rx_valid), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        send(8'hA5, 1'b1, -1);
        k_a5 = k_last;
        repeat (10) @(negedge clk);
        check("a5 latency", 32'(rise_n - k_a5), 32'd155);
        check("a5 data", 32'(rx_data), 32'hA5);
        check("a5 valid dropped", 32'(rx_valid), 32'h0);

        send(8'h3C, 1'b0, -1);
        repeat (40) @(negedge clk);
        check("busy line low", 32'(busy), 32'h1);
        check("3c ferr count", 32'(ferr_cnt), 32'd1);
        check("3c no valid", 32'(rises), 32'd1);
        rx = 1'b1;
        be[be.size() - 1] = cyc + 3;
        repeat (10) @(negedge clk);
        check("busy after high", 32'(busy), 32'h0);

        send(8'h5A, 1'b1, -1);
        repeat (10) @(negedge clk);
        check("5a data", 32'(rx_data), 32'h5A);

        glitch(4);
        repeat (30) @(negedge clk);
        check("glitch rises", 32'(rises), 32'd2);
        check("glitch ferr", 32'(ferr_cnt), 32'd1);

        rx_ready = 1'b0;
        send(8'h11, 1'b1, -1);
        send(8'h22, 1'b1, -1);
        repeat (10) @(negedge clk);
        check("ovr held data", 32'(rx_data), 32'h11);
        check("ovr held valid", 32'(rx_valid), 32'h1);
        check("ovr count", 32'(ovr_cnt), 32'd1);
        rx_ready = 1'b1;
        @(negedge clk);
        check("ready clears", 32'(rx_valid), 32'h0);
        repeat (10) @(negedge clk);

        send(8'hFF, 1'b1, 4);
        repeat (10) @(negedge clk);
        check("rst no valid", 32'(rises), 32'd3);
        check("rst cleared data", 32'(rx_data), 32'h00);
        send(8'h81, 1'b1, -1);
        repeat (10) @(negedge clk);
        check("81 data", 32'(rx_data), 32'h81);
        check("final rises", 32'(rises), 32'd4);
        check("final ferr", 32'(ferr_cnt), 32'd1);
        check("final ovr", 32'(ovr_cnt), 32'd1);
        for (int i = 0; i < rise_data.size() && i < 4; i++)
            check("rise byte", 32'(rise_data[i]), 32'(exp_r[i]));

        send2(8'h00, 885);
        send2(8'hFF, 851);
        send2(8'h55, 885);
        repeat (1000) @(negedge clk);
        check("skew count", 32'(got2.size()), 32'd3);
        for (int i = 0; i < got2.size() && i < 3; i++)
            check("skew byte", 32'(got2[i]), 32'(exp_s[i]));
        check("skew errors", 32'(err2), 32'd0);
        check("skew idle", 32'(busy2), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
